// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern classifier: relation class codes,
// scan FSM states and a helper for index widths.
package pattern_pkg;

   // Relation class codes: bit0 = input is a subset of the template,
   // bit1 = template is a subset of the input.
   localparam logic [1:0] CLS_ANTI  = 2'b00;
   localparam logic [1:0] CLS_SUB   = 2'b01;
   localparam logic [1:0] CLS_SUPER = 2'b10;
   localparam logic [1:0] CLS_EQ    = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_classifier_seq_if.sv
// Vector-in / result-beat-out stream bundle of the pattern classifier.
// The slave modport is the classifier, the master modport is its environment.
interface pattern_classifier_seq_if
   import pattern_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_TEMPL = 4
);
   localparam int IDX_W = idx_width(NUM_TEMPL);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;

   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [1:0]       out_class;
   logic [CNT_W-1:0] out_cnt;
   logic             out_last;
   logic [IDX_W-1:0] out_best_idx;
   logic [CNT_W-1:0] out_best_cnt;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_idx, out_class, out_cnt, out_last,
             out_best_idx, out_best_cnt
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_idx, out_class, out_cnt, out_last,
             out_best_idx, out_best_cnt
   );

endinterface

// File: rtl/pattern_compare.sv
// Combinational set-relation compare of one vector against one template:
// subset/superset flags plus the popcount of the overlap.
module pattern_compare #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec,
   input  logic [WIDTH-1:0] tmpl,
   output logic [1:0]       cls,
   output logic [CNT_W-1:0] cnt
);

   logic is_sub;
   logic is_super;

   // vec subset of tmpl: no bit set in vec that is clear in tmpl (and vice versa).
   assign is_sub   = &(~vec | tmpl);
   assign is_super = &(~tmpl | vec);
   assign cls      = {is_super, is_sub};

   // Overlap popcount.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign a default first,
      // so the running sum is read back in order and no latch is inferred.
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + CNT_W'(vec[i] & tmpl[i]);
      end
   end

endmodule

// File: rtl/pattern_classifier_seq.sv
// Sequential set-relation classifier: accepts one vector, then scans the
// stored templates one per cycle, emitting class, overlap count and the
// running best-overlap template on each result beat.
module pattern_classifier_seq
   import pattern_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_TEMPL = 4,
   parameter int IDX_W     = idx_width(NUM_TEMPL),
   parameter int CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [WIDTH-1:0]        wr_data,
   pattern_classifier_seq_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEMPL - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] latched;
   logic [WIDTH-1:0] templ [NUM_TEMPL];
   logic [IDX_W-1:0] best_idx;
   logic [CNT_W-1:0] best_cnt;

   logic [WIDTH-1:0] tmpl_sel;
   logic [1:0]       cur_cls;
   logic [CNT_W-1:0] cur_cnt;
   logic             load;
   logic             take_new;
   logic [IDX_W-1:0] next_best_idx;
   logic [CNT_W-1:0] next_best_cnt;

   // The template under scan; a write in the same cycle lands only at the edge,
   // so the beat built this cycle sees the old value.
   assign tmpl_sel = templ[idx];

   pattern_compare #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_compare (
      .vec  (latched),
      .tmpl (tmpl_sel),
      .cls  (cur_cls),
      .cnt  (cur_cnt)
   );

   assign bus.in_ready = (state == IDLE);
   assign load         = (state == SCAN) && (!bus.out_valid || bus.out_ready);

   // Running best including the current template; strict '>' keeps the lower index on ties.
   always_comb begin
      take_new      = (idx == '0) || (cur_cnt > best_cnt);
      next_best_idx = take_new ? idx : best_idx;
      next_best_cnt = take_new ? cur_cnt : best_cnt;
   end

   // Template store: written any time, out-of-range indices dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the template array is reset on purpose: templates must read as
         // zero after reset, so this store is built from flops, not a RAM macro.
         for (int i = 0; i < NUM_TEMPL; i++) begin
            templ[i] <= '0;
         end
      end else if (wr_en && (int'(wr_idx) < NUM_TEMPL)) begin
         templ[wr_idx] <= wr_data;
      end
   end

   // Scan FSM with registered result beat and best tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: all state updates here use non-blocking '<=' so every register
         // samples pre-edge values regardless of statement order.
         state            <= IDLE;
         idx              <= '0;
         latched          <= '0;
         best_idx         <= '0;
         best_cnt         <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_idx      <= '0;
         bus.out_class    <= CLS_ANTI;
         bus.out_cnt      <= '0;
         bus.out_last     <= 1'b0;
         bus.out_best_idx <= '0;
         bus.out_best_cnt <= '0;
      end else begin
         if (load) begin
            bus.out_valid    <= 1'b1;
            bus.out_idx      <= idx;
            bus.out_class    <= cur_cls;
            bus.out_cnt      <= cur_cnt;
            bus.out_last     <= (idx == LAST_IDX);
            bus.out_best_idx <= next_best_idx;
            bus.out_best_cnt <= next_best_cnt;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  latched  <= bus.in_data;
                  idx      <= '0;
                  best_idx <= '0;
                  best_cnt <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (load) begin
                  best_idx <= next_best_idx;
                  best_cnt <= next_best_cnt;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_classifier_seq.sv
// Self-checking bench for pattern_classifier_seq: directed scenarios plus
// randomized vectors/templates against a set-level reference model.
module tb_pattern_classifier_seq;
   import pattern_pkg::*;

   localparam int W  = 16;
   localparam int NT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_idx = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr3_en = 1'b0;
   logic [1:0]    wr3_idx = '0;
   logic [W-1:0]  wr3_data = '0;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] model  [NT];
   logic [W-1:0] model3 [3];

   pattern_classifier_seq_if #(.WIDTH(W), .NUM_TEMPL(NT)) bus  ();
   pattern_classifier_seq_if #(.WIDTH(W), .NUM_TEMPL(3))  bus3 ();

   pattern_classifier_seq #(.WIDTH(W), .NUM_TEMPL(NT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .bus     (bus)
   );

   pattern_classifier_seq #(.WIDTH(W), .NUM_TEMPL(3)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr3_en),
      .wr_idx  (wr3_idx),
      .wr_data (wr3_data),
      .bus     (bus3)
   );

   always #5 clk = ~clk;

   // Set relation from its definition: L subset of T means no bit of L outside T.
   function automatic logic [1:0] ref_class(input logic [W-1:0] l, input logic [W-1:0] t);
      logic sub, sup;
      sub = ((l & ~t) == '0);
      sup = ((t & ~l) == '0);
      return {sup, sub};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_t(input int i, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_idx  = 2'(i);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      model[i] = d;
   endtask

   // Send one vector and collect all NT beats.
   // mode 0: out_ready=1; mode 1: random out_ready; mode 2: hold first beat 3 cycles.
   // wr_iter >= 0 drives a template write on that sample after acceptance.
   task automatic run_vec(input logic [W-1:0] vec, input int mode, input int wr_iter,
                          input logic [1:0] wi, input logic [W-1:0] wd, input string tag);
      logic [1:0] e_cls [NT];
      int         e_cnt [NT];
      int         bi, bc, got, iter, seen, guard;
      logic       hold;
      logic [16:0] saved, cur;
      bc = -1;
      bi = 0;
      for (int k = 0; k < NT; k++) begin
         e_cls[k] = ref_class(vec, model[k]);
         e_cnt[k] = $countones(vec & model[k]);
         if (e_cnt[k] > bc) begin
            bc = e_cnt[k];
            bi = k;
         end
      end
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         tick();
         guard++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("FAIL %s accept: in_ready never rose", tag);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vec;
      tick();
      bus.in_valid = 1'b0;
      got = 0; iter = 0; seen = 0; hold = 1'b0; saved = '0;
      while (got < NT && iter < 100) begin
         wr_en   = (iter == wr_iter);
         wr_idx  = wi;
         wr_data = wd;
         cur = {bus.out_idx, bus.out_class, bus.out_cnt, bus.out_last,
                bus.out_best_idx, bus.out_best_cnt};
         if (hold) begin
            checks++;
            if (!bus.out_valid || cur !== saved) begin
               errors++;
               $display("FAIL %s hold: valid %b fields %h exp %h", tag, bus.out_valid, cur, saved);
            end
         end
         if (mode != 1 && got > 0) begin
            checks++;
            if (!bus.out_valid) begin
               errors++;
               $display("FAIL %s gap: no beat after beat %0d", tag, got - 1);
            end
         end
         if (!(bus.out_valid && bus.out_last)) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s in_ready during scan: got %b exp 0", tag, bus.in_ready);
            end
         end
         if (bus.out_valid) seen++;
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = (seen > 3);
         endcase
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (int'(bus.out_idx) !== got || bus.out_class !== e_cls[got] ||
                int'(bus.out_cnt) !== e_cnt[got] || bus.out_last !== (got == NT - 1)) begin
               errors++;
               $display("FAIL %s beat %0d: idx %0d cls %b cnt %0d last %b exp idx %0d cls %b cnt %0d last %b",
                        tag, got, bus.out_idx, bus.out_class, bus.out_cnt, bus.out_last,
                        got, e_cls[got], e_cnt[got], (got == NT - 1));
            end
            if (got == NT - 1) begin
               checks++;
               if (int'(bus.out_best_idx) !== bi || int'(bus.out_best_cnt) !== bc) begin
                  errors++;
                  $display("FAIL %s best: idx %0d cnt %0d exp idx %0d cnt %0d",
                           tag, bus.out_best_idx, bus.out_best_cnt, bi, bc);
               end
            end
            got++;
         end
         hold  = bus.out_valid && !bus.out_ready;
         saved = cur;
         if (got < NT) begin
            tick();
            iter++;
         end
      end
      wr_en = 1'b0;
      checks++;
      if (got < NT) begin
         errors++;
         $display("FAIL %s timeout: got %0d beats exp %0d", tag, got, NT);
      end
      if (mode == 0) begin
         checks++;
         if (iter !== NT || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: last beat at cycle %0d in_ready %b exp cycle %0d in_ready 1",
                     tag, iter, bus.in_ready, NT);
         end
      end
   endtask

   task automatic load_standard();
      write_t(0, 16'h00FF);
      write_t(1, 16'h000F);
      write_t(2, 16'h0F0F);
      write_t(3, 16'hF000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== '0 ||
          bus.out_class !== 2'b00 || bus.out_cnt !== '0 || bus.out_last !== 1'b0 ||
          bus.out_best_idx !== '0 || bus.out_best_cnt !== '0) begin
         errors++;
         $display("FAIL reset state: valid %b ready %b idx %0d cls %b cnt %0d last %b best %0d/%0d",
                  bus.out_valid, bus.in_ready, bus.out_idx, bus.out_class, bus.out_cnt,
                  bus.out_last, bus.out_best_idx, bus.out_best_cnt);
      end
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < NT; k++) model[k] = '0;
      run_vec(16'hFFFF, 0, -1, 2'd0, '0, "zero_tmpl_ffff");
      run_vec(16'h0000, 0, -1, 2'd0, '0, "zero_tmpl_0000");
   endtask

   task automatic test_classify();
      load_standard();
      run_vec(16'h00FF, 0, -1, 2'd0, '0, "std_00ff");
      run_vec(16'h0003, 0, -1, 2'd0, '0, "std_0003");
   endtask

   task automatic test_stall();
      run_vec(16'h00FF, 2, -1, 2'd0, '0, "stall_00ff");
   endtask

   task automatic test_mid_write();
      run_vec(16'h00FF, 0, 2, 2'd2, 16'hFFFF, "midwr_old");
      model[2] = 16'hFFFF;
      run_vec(16'h00FF, 0, -1, 2'd0, '0, "midwr_new");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++) begin
         run_vec(16'($urandom), 0, -1, 2'd0, '0, "b2b");
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            write_t(int'($urandom_range(0, NT - 1)), 16'($urandom));
         end
         run_vec(16'($urandom), 1, -1, 2'd0, '0, "rand");
      end
   endtask

   task automatic test_reset_mid_scan();
      load_standard();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h00FF;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1) begin
         errors++;
         $display("FAIL midrst pre: valid %b idx %0d exp valid 1 idx 1", bus.out_valid, bus.out_idx);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_cnt !== '0) begin
         errors++;
         $display("FAIL midrst abort: valid %b ready %b cnt %0d exp 0 1 0",
                  bus.out_valid, bus.in_ready, bus.out_cnt);
      end
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < NT; k++) model[k] = '0;
      run_vec(16'h00FF, 0, -1, 2'd0, '0, "midrst_after");
   endtask

   // NUM_TEMPL=3 build: index 3 does not exist, its write must be dropped.
   task automatic test_oob_write();
      logic [W-1:0] vec;
      int got, iter, bi, bc, ec;
      for (int k = 0; k < 3; k++) begin
         model3[k] = 16'($urandom);
         wr3_en = 1'b1; wr3_idx = 2'(k); wr3_data = model3[k];
         tick();
      end
      wr3_idx = 2'd3; wr3_data = 16'hFFFF;
      tick();
      wr3_en = 1'b0;
      vec = 16'($urandom) | 16'h8001;
      bc = -1; bi = 0;
      for (int k = 0; k < 3; k++) begin
         ec = $countones(vec & model3[k]);
         if (ec > bc) begin bc = ec; bi = k; end
      end
      bus3.out_ready = 1'b1;
      bus3.in_valid  = 1'b1;
      bus3.in_data   = vec;
      tick();
      bus3.in_valid = 1'b0;
      got = 0; iter = 0;
      while (got < 3 && iter < 20) begin
         if (bus3.out_valid) begin
            ec = $countones(vec & model3[got]);
            checks++;
            if (int'(bus3.out_idx) !== got || int'(bus3.out_cnt) !== ec ||
                bus3.out_class !== ref_class(vec, model3[got]) || bus3.out_last !== (got == 2)) begin
               errors++;
               $display("FAIL oob beat %0d: idx %0d cls %b cnt %0d last %b exp cls %b cnt %0d",
                        got, bus3.out_idx, bus3.out_class, bus3.out_cnt, bus3.out_last,
                        ref_class(vec, model3[got]), ec);
            end
            if (got == 2) begin
               checks++;
               if (int'(bus3.out_best_idx) !== bi || int'(bus3.out_best_cnt) !== bc) begin
                  errors++;
                  $display("FAIL oob best: idx %0d cnt %0d exp %0d %0d",
                           bus3.out_best_idx, bus3.out_best_cnt, bi, bc);
               end
            end
            got++;
         end
         if (got < 3) begin
            tick();
            iter++;
         end
      end
      checks++;
      if (got < 3) begin
         errors++;
         $display("FAIL oob timeout: got %0d beats exp 3", got);
      end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus3.in_valid  = 1'b0;
      bus3.in_data   = '0;
      bus3.out_ready = 1'b1;
      test_reset();
      test_classify();
      test_stall();
      test_mid_write();
      test_back_to_back();
      test_random();
      test_reset_mid_scan();
      test_oob_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_classifier_seq.md
Name: pattern_classifier_seq

Overview:
- Sequential, parametrised set-relation classifier for binary input vectors.
- Holds NUM_TEMPL writable weight templates.
- Accepts one input vector per valid/ready handshake, then scans the templates one per cycle.
- Per template, emits the relation class (anti/sub/super/eq) and the overlap popcount; on the final beat also emits the best-overlap template. Sits between the vector source and downstream decision logic in the detector datapath.

Parameters:
- WIDTH, 16, bit width of input vectors and templates.
- NUM_TEMPL, 4, number of stored templates (>=1).
- IDX_W, $clog2(NUM_TEMPL) (min 1), template index width.
- CNT_W, $clog2(WIDTH+1), popcount width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  template write strobe.
- wr_idx  in  IDX_W  template index to write.
- wr_data  in  WIDTH  template value.
- in_valid  in  1  input vector valid.
- in_ready  out  1  classifier can accept a vector.
- in_data  in  WIDTH  input vector.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts beat.
- out_idx  out  IDX_W  template index of this beat.
- out_class  out  2  bit0 = sub (in ⊆ tmpl), bit1 = super (tmpl ⊆ in); 00 anti, 01 sub, 10 super, 11 eq.
- out_cnt  out  CNT_W  popcount(in & tmpl).
- out_last  out  1  final beat of the scan.
- out_best_idx  out  IDX_W  index of max out_cnt; valid only when out_last.
- out_best_cnt  out  CNT_W  that max count; valid only when out_last.

Behaviour:
- Reset (async assert, sync deassert by design use):
  - state=IDLE, scan idx=0, all templates=0.
  - out_valid=0 and all out_* fields 0; best trackers 0.
  - Reset mid-scan aborts the scan with no partial beat retained.
- Relation classes, computed on the latched vector L against template T:
  - sub = &(~L | T).
  - super = &(~T | L).
  - L=0 and T=0 yields eq.
- Template writes:
  - Allowed in any state; take effect at the clock edge.
  - A beat computed in the same cycle uses the pre-write value.
  - wr_idx >= NUM_TEMPL is ignored.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data to L, idx=0, best_cnt=0, best_idx=0, go to SCAN.
  - Acceptance in IDLE is allowed while a final beat is still pending on the output.
- FSM SCAN:
  - in_ready=0.
  - A beat is loaded when (!out_valid || out_ready). The load writes out_idx=idx, out_class, out_cnt, out_valid=1, and sets out_last=(idx==NUM_TEMPL-1).
  - Best tracking: update when cnt > best_cnt; on ties the lower index wins.
  - out_best_* carry the running best including the current beat.
  - idx increments; after the last load, return to IDLE.
- Output register, no load this cycle: out_valid && out_ready clears out_valid. While out_valid && !out_ready, every out_* field holds stable.
- Latency and throughput:
  - Vector accepted at edge t gives the first beat visible after edge t+1.
  - With out_ready=1, beats arrive on consecutive cycles and in_ready returns after edge t+NUM_TEMPL.
  - Throughput is one vector per NUM_TEMPL+1 cycles.
- NUM_TEMPL=1: every beat has out_last=1.

Decomposition:
- Package pattern_pkg:
  - class encoding constants CLS_ANTI=2'b00, CLS_SUB=2'b01, CLS_SUPER=2'b10, CLS_EQ=2'b11.
  - FSM state enum {IDLE, SCAN}.
- Sub-module pattern_compare: combinational, parametrised by WIDTH. Takes (vec, tmpl) and produces (cls[1:0], cnt[CNT_W-1:0]). Instantiated once on the muxed template.

Test Plan (WIDTH=16, NUM_TEMPL=4):
- Templates T0..T3 = 00FF, 000F, 0F0F, F000; input 00FF with out_ready=1 -> beats (idx,class,cnt) = (0,11,8), (1,10,4), (2,00,4), (3,00,0). Beat 3 has out_last=1, best_idx=0, best_cnt=8.
- Same templates, input 0003 -> classes 01, 01, 01, 00; cnts 2, 2, 2, 0; best_idx=0 (tie, lowest index wins).
- After reset with all templates zero, input FFFF -> all four classes 10, cnts 0, best_idx=0. Input 0000 -> all classes 11.
- Hold out_ready=0 for 3 cycles after the first beat -> out_* fields stable, in_ready=0, no beat lost. On release, beats 1..3 follow back-to-back.
- During the cycle computing idx 2, write wr_idx=2, wr_data=FFFF -> beat 2 uses 0F0F. The next vector sees FFFF. A write to wr_idx of a non-existent template (NUM_TEMPL=3 build, wr_idx=3) is ignored.
- Assert rst_n=0 mid-scan after beat 1 -> out_valid=0 immediately, in_ready=1 after release. Templates are zero, and a new vector scans from idx 0.
